// File: rtl/scan_ctrl8.sv
// scan_ctrl8: prescaled 8-digit hex display scanner with frame-synced
// shadow register, leading-zero blanking and registered 7-seg outputs.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   en                 scan enable (freezes scan, blanks outputs when 0)
//   load, data_in[32]  strobe + new display word (digit i = [4i+3:4i])
//   mask[8]            per-digit enable, 0 blanks that digit
//   nib_in[4]          nibble returned from the external select8 mux
//   mux_data[32]       shadow word to mux datain
//   sel[3]             digit index to mux sel
//   an_n[8], seg_n[7]  registered active-low anodes / segments (gfedcba)
//   pend               a loaded word waits for the frame boundary
//   frame              one-cycle pulse following each 7->0 wrap
module scan_ctrl8 #(
    parameter int unsigned DIV = 50000,
    parameter bit          LZB = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  mask,
    input  logic [3:0]  nib_in,
    output logic [31:0] mux_data,
    output logic [2:0]  sel,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        pend,
    output logic        frame
);

    localparam logic [19:0] TERM = 20'(DIV - 1);

    logic [19:0] cnt_q, cnt_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] pending_q, pending_d;
    logic        pend_q, pend_d;
    logic        frame_q, frame_d;
    logic [7:0]  an_n_q, an_n_d;
    logic [6:0]  seg_n_q, seg_n_d;

    logic        tick;
    logic        wrap;
    logic        upper_zero;
    logic        blank;
    logic [6:0]  seg_dec;

    always_comb begin
        tick = en && (cnt_q == TERM);
        wrap = tick && (sel_q == 3'd7);

        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? 20'd0 : cnt_q + 20'd1;
        end
        sel_d   = tick ? sel_q + 3'd1 : sel_q;
        frame_d = wrap;

        // A load coinciding with the wrap bypasses the pending buffer so
        // the newest word is never deferred by a whole frame.
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        if (load && wrap) begin
            shadow_d = data_in;
            pend_d   = 1'b0;
        end else if (wrap && pend_q) begin
            shadow_d = pending_q;
            pend_d   = 1'b0;
        end else if (load) begin
            pending_d = data_in;
            pend_d    = 1'b1;
        end

        // Slot is a leading zero when it and every higher nibble are 0.
        upper_zero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i >= int'(sel_q) && shadow_q[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        blank = !mask[sel_q] ||
                (LZB && (sel_q != 3'd0) && upper_zero);

        seg_dec = 7'h7F;
        case (nib_in)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = 7'h7F;
        endcase

        an_n_d  = 8'hFF;
        seg_n_d = 7'h7F;
        if (en && !blank) begin
            an_n_d  = ~(8'h01 << sel_q);
            seg_n_d = seg_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 20'd0;
            sel_q     <= 3'd0;
            shadow_q  <= 32'd0;
            pending_q <= 32'd0;
            pend_q    <= 1'b0;
            frame_q   <= 1'b0;
            an_n_q    <= 8'hFF;
            seg_n_q   <= 7'h7F;
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            frame_q   <= frame_d;
            an_n_q    <= an_n_d;
            seg_n_q   <= seg_n_d;
        end
    end

    assign mux_data = shadow_q;
    assign sel      = sel_q;
    assign an_n     = an_n_q;
    assign seg_n    = seg_n_q;
    assign pend     = pend_q;
    assign frame    = frame_q;

endmodule

// File: tb/tb_scan_ctrl8.sv
// tb_scan_ctrl8: directed bench for scan_ctrl8 with DIV=4, LZB=1.
// The external select8 mux is modelled by a part-select on mux_data.
module tb_scan_ctrl8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  mask;
    logic [3:0]  nib_in;
    logic [31:0] mux_data;
    logic [2:0]  sel;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        pend;
    logic        frame;

    int total = 0;
    int bad   = 0;

    scan_ctrl8 #(.DIV(4), .LZB(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .data_in(data_in), .mask(mask), .nib_in(nib_in),
        .mux_data(mux_data), .sel(sel), .an_n(an_n),
        .seg_n(seg_n), .pend(pend), .frame(frame)
    );

    assign nib_in = mux_data[4*sel +: 4];

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mask = 8'hFF;
        load = 1'b1; data_in = 32'hFFFF_FFFF;
        repeat (3) clk1();
        load = 1'b0;
        total += 6;
        if (an_n !== 8'hFF) begin bad++; $display("FAIL rst_an got=%h exp=ff", an_n); end
        if (seg_n !== 7'h7F) begin bad++; $display("FAIL rst_seg got=%h exp=7f", seg_n); end
        if (pend !== 1'b0) begin bad++; $display("FAIL rst_pend got=%b exp=0", pend); end
        if (mux_data !== 32'h0) begin bad++; $display("FAIL rst_mux got=%h exp=0", mux_data); end
        if (sel !== 3'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", sel); end
        if (frame !== 1'b0) begin bad++; $display("FAIL rst_frame got=%b exp=0", frame); end
    endtask

    // Edge 1 releases reset and loads; wrap lands on edge 32 and 64.
    task automatic test_full_scan();
        rst_n = 1'b1; load = 1'b1; data_in = 32'h1234_5678;
        for (int n = 1; n <= 64; n++) begin
            clk1();
            load = 1'b0;
            total += 3;
            if (frame !== (n == 32 || n == 64)) begin
                bad++; $display("FAIL fs_frame n=%0d got=%b", n, frame);
            end
            if (pend !== (n < 32)) begin
                bad++; $display("FAIL fs_pend n=%0d got=%b", n, pend);
            end
            if (mux_data !== ((n < 32) ? 32'h0 : 32'h1234_5678)) begin
                bad++; $display("FAIL fs_mux n=%0d got=%h", n, mux_data);
            end
            if (n == 1 || n == 5 || n == 33 || n == 37 || n == 64) begin
                logic [7:0] ea;
                logic [6:0] es;
                case (n)
                    1:  begin ea = 8'hFE; es = 7'h40; end
                    5:  begin ea = 8'hFF; es = 7'h7F; end
                    33: begin ea = 8'hFE; es = 7'h00; end
                    37: begin ea = 8'hFD; es = 7'h78; end
                    default: begin ea = 8'h7F; es = 7'h79; end
                endcase
                total += 2;
                if (an_n !== ea) begin
                    bad++; $display("FAIL fs_an n=%0d got=%h exp=%h", n, an_n, ea);
                end
                if (seg_n !== es) begin
                    bad++; $display("FAIL fs_seg n=%0d got=%h exp=%h", n, seg_n, es);
                end
            end
        end
    endtask

    task automatic test_lzb();
        load = 1'b1; data_in = 32'h0000_00A5;
        for (int m = 1; m <= 64; m++) begin
            logic [7:0] ea;
            logic [6:0] es;
            clk1();
            load = 1'b0;
            if (m >= 33 && ((m - 33) % 4 == 0)) begin
                case (m)
                    33: begin ea = 8'hFE; es = 7'h12; end
                    37: begin ea = 8'hFD; es = 7'h08; end
                    default: begin ea = 8'hFF; es = 7'h7F; end
                endcase
                total += 2;
                if (an_n !== ea) begin
                    bad++; $display("FAIL lz_an m=%0d got=%h exp=%h", m, an_n, ea);
                end
                if (seg_n !== es) begin
                    bad++; $display("FAIL lz_seg m=%0d got=%h exp=%h", m, seg_n, es);
                end
            end
        end
    endtask

    task automatic test_frame_sync();
        for (int m = 1; m <= 64; m++) begin
            clk1();
            if (m == 13) begin load = 1'b1; data_in = 32'h1111_1111; end
            if (m == 14) load = 1'b0;
            if (m == 14 || m == 31) begin
                total += 2;
                if (pend !== 1'b1) begin bad++; $display("FAIL sync_pend m=%0d got=%b exp=1", m, pend); end
                if (mux_data !== 32'hA5) begin bad++; $display("FAIL sync_hold m=%0d got=%h exp=a5", m, mux_data); end
            end
            if (m == 32) begin
                total += 3;
                if (pend !== 1'b0) begin bad++; $display("FAIL sync_drop got=%b exp=0", pend); end
                if (mux_data !== 32'h1111_1111) begin bad++; $display("FAIL sync_upd got=%h exp=11111111", mux_data); end
                if (frame !== 1'b1) begin bad++; $display("FAIL sync_frame got=%b exp=1", frame); end
            end
            if (m == 63) begin load = 1'b1; data_in = 32'h2222_2222; end
            if (m == 64) begin
                load = 1'b0;
                total += 3;
                if (mux_data !== 32'h2222_2222) begin bad++; $display("FAIL coinc_mux got=%h exp=22222222", mux_data); end
                if (pend !== 1'b0) begin bad++; $display("FAIL coinc_pend got=%b exp=0", pend); end
                if (frame !== 1'b1) begin bad++; $display("FAIL coinc_frame got=%b exp=1", frame); end
            end
        end
    endtask

    task automatic test_freeze_reset();
        repeat (21) clk1();
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            clk1();
            total += 3;
            if (sel !== 3'd5) begin bad++; $display("FAIL frz_sel k=%0d got=%0d exp=5", k, sel); end
            if (an_n !== 8'hFF) begin bad++; $display("FAIL frz_an k=%0d got=%h exp=ff", k, an_n); end
            if (seg_n !== 7'h7F) begin bad++; $display("FAIL frz_seg k=%0d got=%h exp=7f", k, seg_n); end
        end
        en = 1'b1;
        clk1();
        total += 3;
        if (sel !== 3'd5) begin bad++; $display("FAIL res_sel1 got=%0d exp=5", sel); end
        if (an_n !== 8'hDF) begin bad++; $display("FAIL res_an got=%h exp=df", an_n); end
        if (seg_n !== 7'h24) begin bad++; $display("FAIL res_seg got=%h exp=24", seg_n); end
        clk1();
        total += 1;
        if (sel !== 3'd5) begin bad++; $display("FAIL res_sel2 got=%0d exp=5", sel); end
        clk1();
        total += 1;
        if (sel !== 3'd6) begin bad++; $display("FAIL res_sel3 got=%0d exp=6", sel); end
        load = 1'b1; data_in = 32'h3333_3333;
        clk1();
        load = 1'b0;
        total += 1;
        if (pend !== 1'b1) begin bad++; $display("FAIL pre_rst_pend got=%b exp=1", pend); end
        rst_n = 1'b0;
        clk1();
        total += 6;
        if (an_n !== 8'hFF) begin bad++; $display("FAIL mrst_an got=%h exp=ff", an_n); end
        if (seg_n !== 7'h7F) begin bad++; $display("FAIL mrst_seg got=%h exp=7f", seg_n); end
        if (sel !== 3'd0) begin bad++; $display("FAIL mrst_sel got=%0d exp=0", sel); end
        if (mux_data !== 32'h0) begin bad++; $display("FAIL mrst_mux got=%h exp=0", mux_data); end
        if (pend !== 1'b0) begin bad++; $display("FAIL mrst_pend got=%b exp=0", pend); end
        if (frame !== 1'b0) begin bad++; $display("FAIL mrst_frame got=%b exp=0", frame); end
    endtask

    task automatic test_mask();
        rst_n = 1'b1; mask = 8'h0F;
        load = 1'b1; data_in = 32'h89AB_CDEF;
        for (int m = 1; m <= 64; m++) begin
            logic [7:0] ea;
            logic [6:0] es;
            clk1();
            load = 1'b0;
            total += 1;
            if (an_n[7:4] !== 4'hF) begin
                bad++; $display("FAIL mask_hi m=%0d got=%h exp=f", m, an_n[7:4]);
            end
            if (m >= 33 && ((m - 33) % 4 == 0)) begin
                case (m)
                    33: begin ea = 8'hFE; es = 7'h0E; end
                    37: begin ea = 8'hFD; es = 7'h06; end
                    41: begin ea = 8'hFB; es = 7'h21; end
                    45: begin ea = 8'hF7; es = 7'h46; end
                    default: begin ea = 8'hFF; es = 7'h7F; end
                endcase
                total += 2;
                if (an_n !== ea) begin
                    bad++; $display("FAIL mask_an m=%0d got=%h exp=%h", m, an_n, ea);
                end
                if (seg_n !== es) begin
                    bad++; $display("FAIL mask_seg m=%0d got=%h exp=%h", m, seg_n, es);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        data_in = 32'h0; mask = 8'hFF;
        test_reset();
        test_full_scan();
        test_lzb();
        test_frame_sync();
        test_freeze_reset();
        test_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
